// File: rtl/vga_pixel_pipe.sv
// Colour stage behind the VGA timing controller: two-stage pixel pipeline drawing a grid
// background and a button-steered box, with syncs and blank delayed to stay aligned with colour.
module vga_pixel_pipe #(
    parameter int N         = 15,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 4,
    parameter int GRID_LOG2 = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_en,
    input  logic [N:0]   horiz_count,
    input  logic [N:0]   vert_count,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic         blank_in,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    output logic [7:0]   R,
    output logic [7:0]   G,
    output logic [7:0]   B,
    output logic         horiz_sync,
    output logic         vert_sync,
    output logic         vga_blank,
    output logic [N:0]   box_x,
    output logic [N:0]   box_y,
    output logic         frame_tick
);

    localparam int W  = N + 1;
    localparam int W1 = N + 2;

    localparam logic [N:0] X_MAX   = W'(H_ACTIVE - BOX_SIZE);
    localparam logic [N:0] Y_MAX   = W'(V_ACTIVE - BOX_SIZE);
    localparam logic [N:0] X_HOME  = W'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [N:0] Y_HOME  = W'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [N:0] V_TICK  = W'(V_ACTIVE);
    localparam logic [N:0] STEP_W  = W'(STEP);
    localparam logic [N+1:0] SIZE_W = W1'(BOX_SIZE);

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;

    logic [N+1:0] box_x_end;
    logic [N+1:0] box_y_end;
    logic [N+1:0] x_inc;
    logic [N+1:0] y_inc;
    logic         in_box;
    logic         grid;

    logic         s1_hsync;
    logic         s1_vsync;
    logic         s1_blank;
    logic         s1_in_box;
    logic         s1_grid;

    logic [3:0]   btn_raw;
    logic [3:0]   btn_meta;
    logic [3:0]   btn_sync;
    logic [3:0]   btn_flag;
    logic [N:0]   next_x;
    logic [N:0]   next_y;

    // One extra bit on the box end so the compare cannot wrap at the right/bottom edge.
    assign box_x_end = {1'b0, box_x} + SIZE_W;
    assign box_y_end = {1'b0, box_y} + SIZE_W;

    assign in_box = (horiz_count >= box_x) && ({1'b0, horiz_count} < box_x_end) &&
                    (vert_count  >= box_y) && ({1'b0, vert_count}  < box_y_end);
    assign grid   = (horiz_count[GRID_LOG2-1:0] == '0) || (vert_count[GRID_LOG2-1:0] == '0);

    assign frame_tick = reset && pix_en && (vert_count == V_TICK) && (horiz_count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            s1_blank   <= 1'b0;
            s1_in_box  <= 1'b0;
            s1_grid    <= 1'b0;
            R          <= 8'h00;
            G          <= 8'h00;
            B          <= 8'h00;
            horiz_sync <= 1'b1;
            vert_sync  <= 1'b1;
            vga_blank  <= 1'b0;
        end else if (pix_en) begin
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
            s1_blank   <= blank_in;
            s1_in_box  <= in_box;
            s1_grid    <= grid;
            horiz_sync <= s1_hsync;
            vert_sync  <= s1_vsync;
            vga_blank  <= s1_blank;
            if (!s1_blank) begin
                {R, G, B} <= 24'h000000;
            end else if (s1_in_box) begin
                {R, G, B} <= 24'hFF0000;
            end else if (s1_grid) begin
                {R, G, B} <= 24'h404040;
            end else begin
                {R, G, B} <= 24'h000020;
            end
        end
    end

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};
    assign x_inc   = {1'b0, box_x} + {1'b0, STEP_W};
    assign y_inc   = {1'b0, box_y} + {1'b0, STEP_W};

    // Opposing directions held together cancel on that axis.
    always_comb begin
        next_x = box_x;
        next_y = box_y;
        if (btn_flag[RIGHT] && !btn_flag[LEFT]) begin
            next_x = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[N:0];
        end else if (btn_flag[LEFT] && !btn_flag[RIGHT]) begin
            next_x = (box_x < STEP_W) ? '0 : box_x - STEP_W;
        end
        if (btn_flag[DOWN] && !btn_flag[UP]) begin
            next_y = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[N:0];
        end else if (btn_flag[UP] && !btn_flag[DOWN]) begin
            next_y = (box_y < STEP_W) ? '0 : box_y - STEP_W;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_flag <= '0;
            box_x    <= X_HOME;
            box_y    <= Y_HOME;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            // A press seen on the tick edge itself is kept for the following frame.
            if (frame_tick) begin
                box_x    <= next_x;
                box_y    <= next_y;
                btn_flag <= btn_sync;
            end else begin
                btn_flag <= btn_flag | btn_sync;
            end
        end
    end

endmodule
